// File: rtl/mem_seq_engine.sv
// rtl/mem_seq_engine.sv - memory fill/copy sequencer on a single-port req/gnt bus
// Walks count elements writing a generated pattern or copying src->dst with independent strides.
module mem_seq_engine #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DIM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [1:0]          mode,
  input  logic [MEM_AW-1:0]   src_base,
  input  logic [MEM_AW-1:0]   dst_base,
  input  logic [DIM_BITS-1:0] src_stride,
  input  logic [DIM_BITS-1:0] dst_stride,
  input  logic [DIM_BITS-1:0] count,
  input  logic [MEM_DW-1:0]   pattern,
  input  logic                abort,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rdata_vld,
  input  logic [MEM_DW-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [DIM_BITS-1:0] xfer_cnt
);

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INV   = 2'd1;
  localparam logic [1:0] MODE_INC   = 2'd2;
  localparam logic [1:0] MODE_COPY  = 2'd3;
  localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [1:0]          mode_q;
  logic [MEM_AW-1:0]   src_addr, dst_addr;
  logic [DIM_BITS-1:0] src_stride_q, dst_stride_q;
  logic [DIM_BITS-1:0] count_q;
  logic [MEM_DW-1:0]   pattern_q;
  logic [DIM_BITS-1:0] idx;
  logic [MEM_DW-1:0]   copy_data;

  logic                start, wr_fire, rd_fire, rd_cap, set_abort;
  logic [DIM_BITS-1:0] idx_inc;
  logic [MEM_DW-1:0]   fill_data;

  assign idx_inc = idx + DIM_ONE;

  // Fill data depends only on latched config and idx, so it is stable across a grant stall.
  always_comb begin
    fill_data = '0;
    case (mode_q)
      MODE_CONST: fill_data = pattern_q;
      MODE_INV:   fill_data = ~(MEM_DW'(idx_inc));
      MODE_INC:   fill_data = pattern_q + MEM_DW'(idx);
      MODE_COPY:  fill_data = copy_data;
      default:    fill_data = '0;
    endcase
  end

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    rd_cap    = 1'b0;
    set_abort = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          start = 1'b1;
          if (count == '0)
            state_d = S_DONE;
          else if (mode == MODE_COPY)
            state_d = S_RD_REQ;
          else
            state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = dst_addr;
        mem_wdata = fill_data;
        if (mem_gnt) begin
          wr_fire = 1'b1;
          if (idx_inc == count_q) begin
            state_d = S_DONE;
          end else if (abort) begin
            set_abort = 1'b1;
            state_d   = S_DONE;
          end else if (mode_q == MODE_COPY) begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = src_addr;
        if (mem_gnt) begin
          rd_fire = 1'b1;
          state_d = S_RD_WAIT;
        end
      end
      // Entered only after the grant edge, so a valid in the grant cycle is never seen here.
      S_RD_WAIT: begin
        busy = 1'b1;
        if (mem_rdata_vld) begin
          rd_cap  = 1'b1;
          state_d = S_WR_REQ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mode_q       <= '0;
      src_addr     <= '0;
      dst_addr     <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      count_q      <= '0;
      pattern_q    <= '0;
      idx          <= '0;
      copy_data    <= '0;
      xfer_cnt     <= '0;
      aborted      <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        mode_q       <= mode;
        src_addr     <= src_base;
        dst_addr     <= dst_base;
        src_stride_q <= src_stride;
        dst_stride_q <= dst_stride;
        count_q      <= count;
        pattern_q    <= pattern;
        idx          <= '0;
        copy_data    <= '0;
        xfer_cnt     <= '0;
        aborted      <= 1'b0;
      end
      // Address accumulators wrap naturally at 2^MEM_AW.
      if (wr_fire) begin
        idx      <= idx_inc;
        xfer_cnt <= xfer_cnt + DIM_ONE;
        dst_addr <= dst_addr + MEM_AW'(dst_stride_q);
      end
      if (rd_fire)
        src_addr <= src_addr + MEM_AW'(src_stride_q);
      if (rd_cap)
        copy_data <= mem_rdata;
      if (set_abort)
        aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_seq_engine.sv
// tb/tb_mem_seq_engine.sv - self-checking bench for mem_seq_engine
module tb_mem_seq_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go, abort;
  logic [1:0]  mode;
  logic [15:0] src_base, dst_base, src_stride, dst_stride, count;
  logic [31:0] pattern;
  logic        mem_req, mem_write, mem_gnt, mem_rdata_vld;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, done, aborted;
  logic [15:0] xfer_cnt;

  always #5 clk = ~clk;

  mem_seq_engine #(.MEM_AW(16), .MEM_DW(32), .DIM_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .src_stride(src_stride), .dst_stride(dst_stride),
    .count(count), .pattern(pattern), .abort(abort),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .aborted(aborted), .xfer_cnt(xfer_cnt)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:65535];
  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [15:0] rd_addr_q[$];
  logic [15:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [15:0] exp_ra[$];

  int cyc = 0;
  int gnt_stall = 0, rd_lat = 1;
  int stab_err = 0, outst_err = 0, req_cycles = 0;
  bit pend_rd = 0;
  int rd_cnt = 0, wait_cnt = 0;
  logic [15:0] pend_addr;
  bit prev_hold = 0;
  logic        prev_write;
  logic [15:0] prev_addr;
  logic [31:0] prev_wdata;

  // Memory responder and bus monitor: drives gnt/rdata at +2, samples the bus at the falling edge.
  initial begin
    mem_gnt = 1'b0; mem_rdata_vld = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n) begin
        mem_gnt = 1'b0; mem_rdata_vld = 1'b0; pend_rd = 0; wait_cnt = 0; prev_hold = 0;
      end else begin
        mem_rdata_vld = 1'b0;
        if (pend_rd) begin
          if (rd_cnt == 0) begin
            mem_rdata_vld = 1'b1; mem_rdata = mem[pend_addr]; pend_rd = 0;
          end else begin
            rd_cnt--;
          end
        end
        if (mem_req) begin
          if (wait_cnt < gnt_stall) begin mem_gnt = 1'b0; wait_cnt++; end
          else begin mem_gnt = 1'b1; wait_cnt = 0; end
        end else begin
          mem_gnt = 1'b0; wait_cnt = 0;
        end
      end
      #3;
      if (rst_n) begin
        if (mem_req) req_cycles++;
        if (prev_hold && (mem_req !== 1'b1 || mem_write !== prev_write ||
            mem_addr !== prev_addr || mem_wdata !== prev_wdata)) stab_err++;
        if (mem_req && pend_rd) outst_err++;
        if (mem_req && mem_gnt) begin
          if (mem_write) begin
            wr_addr_q.push_back(mem_addr); wr_data_q.push_back(mem_wdata); wr_cyc_q.push_back(cyc);
            mem[mem_addr] = mem_wdata;
          end else begin
            rd_addr_q.push_back(mem_addr);
            pend_rd = 1; pend_addr = mem_addr; rd_cnt = rd_lat - 1;
          end
        end
        prev_hold = mem_req && !mem_gnt;
        prev_write = mem_write; prev_addr = mem_addr; prev_wdata = mem_wdata;
      end
    end
  end

  // Reference: element i goes to dst_base + i*dst_stride (mod 2^16); copies see earlier writes.
  task automatic compute_expected(input logic [1:0] md, input logic [15:0] sb, db, ss, ds, cnt,
                                  input logic [31:0] pat);
    logic [31:0] ov [int];
    longint a;
    logic [15:0] da, sa;
    logic [31:0] d;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      a = (longint'(db) + longint'(i) * longint'(ds)) % 65536; da = a[15:0];
      a = (longint'(sb) + longint'(i) * longint'(ss)) % 65536; sa = a[15:0];
      case (md)
        2'd0: d = pat;
        2'd1: d = ~(32'(i + 1));
        2'd2: d = pat + 32'(i);
        default: begin
          d = ov.exists(int'(sa)) ? ov[int'(sa)] : mem[sa];
          exp_ra.push_back(sa);
        end
      endcase
      ov[int'(da)] = d;
      exp_wa.push_back(da); exp_wd.push_back(d);
    end
  endtask

  function automatic int wr_mismatch();
    if (wr_addr_q.size() != exp_wa.size()) return -2;
    foreach (exp_wa[k]) if (wr_addr_q[k] !== exp_wa[k] || wr_data_q[k] !== exp_wd[k]) return k;
    return -1;
  endfunction

  function automatic int rd_mismatch();
    if (rd_addr_q.size() != exp_ra.size()) return -2;
    foreach (exp_ra[k]) if (rd_addr_q[k] !== exp_ra[k]) return k;
    return -1;
  endfunction

  task automatic run_job(input logic [1:0] md, input logic [15:0] sb, db, ss, ds, cnt,
                         input logic [31:0] pat, input int stall, lat, abort_after,
                         output int go_c, done_c, output bit to, output logic ab,
                         output logic [15:0] xc);
    compute_expected(md, sb, db, ss, ds, cnt, pat);
    gnt_stall = stall; rd_lat = lat;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); rd_addr_q.delete();
    stab_err = 0; outst_err = 0; req_cycles = 0;
    done_c = -1; ab = 1'bx; xc = 'x;
    @(posedge clk); #1;
    mode = md; src_base = sb; dst_base = db; src_stride = ss; dst_stride = ds;
    count = cnt; pattern = pat; go = 1'b1; go_c = cyc;
    @(posedge clk); #1;
    mode = 2'($urandom); src_base = 16'($urandom); dst_base = 16'($urandom);
    src_stride = 16'($urandom); dst_stride = 16'($urandom); count = 16'($urandom);
    pattern = $urandom;
    go = (cnt != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    to = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1) go = 1'b0;
      if (abort_after >= 0 && wr_addr_q.size() >= abort_after) abort = 1'b1;
      if (done === 1'b1) begin
        to = 0; done_c = cyc; ab = aborted; xc = xfer_cnt;
        break;
      end
      @(posedge clk); #1;
    end
    go = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 0; abort = 0; mode = 0; src_base = 0; dst_base = 0;
    src_stride = 0; dst_stride = 0; count = 0; pattern = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_write, mem_addr, mem_wdata, busy, done, aborted, xfer_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b wr=%b addr=%h wdata=%h busy=%b done=%b ab=%b xfer=%0d, want all 0",
               mem_req, mem_write, mem_addr, mem_wdata, busy, done, aborted, xfer_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_idle: busy=%b req=%b want 0/0", busy, mem_req);
    end
  endtask

  task automatic test_fill_inv();
    int go_c, done_c, m; bit to; logic ab; logic [15:0] xc;
    run_job(2'd1, 16'h0, 16'h100, 16'h0, 16'h1, 16'd4, 32'h0, 0, 1, -1, go_c, done_c, to, ab, xc);
    m = wr_mismatch();
    checks++;
    if (to || m != -1) begin
      failures++; $display("FAIL fill_inv_writes: timeout=%0d bad_idx=%0d n=%0d want n=4", to, m, wr_addr_q.size());
    end
    checks++;
    if (wr_data_q.size() != 4 || wr_data_q[0] !== 32'hFFFFFFFE || wr_data_q[3] !== 32'hFFFFFFFB ||
        wr_addr_q[3] !== 16'h103) begin
      failures++; $display("FAIL fill_inv_values: first/last data or last addr wrong, want FFFFFFFE/FFFFFFFB @103");
    end
    checks++;
    if (wr_cyc_q.size() != 4 || wr_cyc_q[0] != go_c + 1 || wr_cyc_q[3] != go_c + 4 || done_c != go_c + 5) begin
      failures++; $display("FAIL fill_inv_timing: done at %0d want %0d (go at %0d)", done_c, go_c + 5, go_c);
    end
    checks++;
    if (xc !== 16'd4 || ab !== 1'b0) begin
      failures++; $display("FAIL fill_inv_status: xfer=%0d aborted=%b want 4/0", xc, ab);
    end
  endtask

  task automatic test_fill_inc_stall();
    int go_c, done_c, m; bit to; logic ab; logic [15:0] xc;
    run_job(2'd2, 16'h0, 16'h0, 16'h0, 16'h4, 16'd3, 32'h10, 2, 1, -1, go_c, done_c, to, ab, xc);
    m = wr_mismatch();
    checks++;
    if (to || m != -1 || wr_data_q[2] !== 32'h12 || wr_addr_q[2] !== 16'h8) begin
      failures++; $display("FAIL fill_inc_writes: timeout=%0d bad_idx=%0d want data 10,11,12 at 0,4,8", to, m);
    end
    checks++;
    if (stab_err != 0) begin
      failures++; $display("FAIL fill_inc_stable: %0d unstable stall cycles, want 0", stab_err);
    end
    checks++;
    if (wr_cyc_q.size() != 3 || wr_cyc_q[1] - wr_cyc_q[0] != 3) begin
      failures++; $display("FAIL fill_inc_spacing: grant spacing wrong, want 3 cycles per stalled write");
    end
  endtask

  task automatic test_copy();
    int go_c, done_c, m, r; bit to; logic ab; logic [15:0] xc;
    run_job(2'd3, 16'h200, 16'h300, 16'h2, 16'h1, 16'd3, 32'h0, 0, 2, -1, go_c, done_c, to, ab, xc);
    m = wr_mismatch(); r = rd_mismatch();
    checks++;
    if (to || r != -1) begin
      failures++; $display("FAIL copy_reads: timeout=%0d bad_idx=%0d n=%0d want 200,202,204", to, r, rd_addr_q.size());
    end
    checks++;
    if (m != -1) begin
      failures++; $display("FAIL copy_writes: bad_idx=%0d n=%0d want 3", m, wr_addr_q.size());
    end
    checks++;
    if (outst_err != 0 || stab_err != 0 || xc !== 16'd3) begin
      failures++; $display("FAIL copy_protocol: outstanding=%0d unstable=%0d xfer=%0d want 0/0/3", outst_err, stab_err, xc);
    end
  endtask

  task automatic test_wrap();
    int go_c, done_c, m; bit to; logic ab; logic [15:0] xc;
    run_job(2'd0, 16'h0, 16'hFFFF, 16'h0, 16'h1, 16'd3, 32'hA5A5_0001, 0, 1, -1, go_c, done_c, to, ab, xc);
    m = wr_mismatch();
    checks++;
    if (to || m != -1 || wr_addr_q[1] !== 16'h0000 || wr_addr_q[2] !== 16'h0001) begin
      failures++; $display("FAIL wrap_addrs: timeout=%0d bad_idx=%0d want FFFF,0000,0001", to, m);
    end
  endtask

  task automatic test_count_zero();
    int go_c, done_c; bit to; logic ab; logic [15:0] xc;
    run_job(2'd0, 16'h0, 16'h40, 16'h0, 16'h1, 16'd0, 32'h1, 0, 1, -1, go_c, done_c, to, ab, xc);
    checks++;
    if (to || done_c != go_c + 1 || req_cycles != 0 || xc !== 16'd0) begin
      failures++; $display("FAIL count_zero: done at %0d want %0d, req cycles %0d want 0, xfer %0d want 0",
                           done_c, go_c + 1, req_cycles, xc);
    end
  endtask

  task automatic test_abort_stall();
    int go_c, done_c; bit to; logic ab; logic [15:0] xc;
    run_job(2'd2, 16'h0, 16'h500, 16'h0, 16'h1, 16'd8, 32'h77, 2, 1, 1, go_c, done_c, to, ab, xc);
    abort = 1'b0;
    checks++;
    if (to || wr_addr_q.size() != 2 || ab !== 1'b1 || xc !== 16'd2) begin
      failures++; $display("FAIL abort_stall: writes=%0d aborted=%b xfer=%0d want 2/1/2", wr_addr_q.size(), ab, xc);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (aborted !== 1'b1) begin
      failures++; $display("FAIL abort_held: aborted=%b want 1 until next go", aborted);
    end
  endtask

  task automatic test_abort_at_go();
    int go_c, done_c; bit to; logic ab; logic [15:0] xc;
    abort = 1'b1;
    run_job(2'd0, 16'h0, 16'h600, 16'h0, 16'h1, 16'd5, 32'h5, 0, 1, -1, go_c, done_c, to, ab, xc);
    abort = 1'b0;
    checks++;
    if (to || wr_addr_q.size() != 1 || ab !== 1'b1 || xc !== 16'd1) begin
      failures++; $display("FAIL abort_at_go: writes=%0d aborted=%b xfer=%0d want 1/1/1", wr_addr_q.size(), ab, xc);
    end
  endtask

  task automatic test_random();
    int go_c, done_c, m, r; bit to; logic ab; logic [15:0] xc;
    logic [1:0] md; logic [15:0] cnt; int stall;
    for (int j = 0; j < 10; j++) begin
      md = 2'($urandom_range(0, 3)); cnt = 16'($urandom_range(1, 12)); stall = $urandom_range(0, 2);
      run_job(md, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 9)), 16'($urandom), cnt,
              $urandom, stall, $urandom_range(1, 3), -1, go_c, done_c, to, ab, xc);
      m = wr_mismatch(); r = rd_mismatch();
      checks++;
      if (to || m != -1 || r != -1 || xc !== cnt || ab !== 1'b0 || stab_err != 0 || outst_err != 0) begin
        failures++;
        $display("FAIL random_%0d mode=%0d cnt=%0d: timeout=%0d wr_bad=%0d rd_bad=%0d xfer=%0d ab=%b unstable=%0d outstanding=%0d",
                 j, md, cnt, to, m, r, xc, ab, stab_err, outst_err);
      end
      if (md != 2'd3 && stall == 0) begin
        checks++;
        if (done_c != go_c + int'(cnt) + 1) begin
          failures++; $display("FAIL random_%0d_throughput: done at %0d want %0d", j, done_c, go_c + int'(cnt) + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    bit seen, pulse;
    gnt_stall = 1; rd_lat = 3;
    @(posedge clk); #1;
    mode = 2'd3; src_base = 16'h900; dst_base = 16'hA00; src_stride = 16'h1; dst_stride = 16'h1;
    count = 16'd4; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (mem_req === 1'b1 && mem_write === 1'b1) seen = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {mem_req, mem_write, mem_addr, mem_wdata, busy, done, aborted, xfer_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid_copy: reached_write=%0d req=%b wr=%b addr=%h wdata=%h busy=%b xfer=%0d want all 0",
               seen, mem_req, mem_write, mem_addr, mem_wdata, busy, xfer_cnt);
    end
    pulse = 0;
    repeat (2) begin @(posedge clk); #1; if (done !== 1'b0) pulse = 1; end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (done !== 1'b0 || mem_req !== 1'b0) pulse = 1; end
    checks++;
    if (pulse) begin
      failures++; $display("FAIL reset_no_done: saw done or req after mid-run reset, want none");
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    test_reset();
    test_fill_inv();
    test_fill_inc_stall();
    test_copy();
    test_wrap();
    test_count_zero();
    test_abort_stall();
    test_abort_at_go();
    test_random();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
